// File: rtl/window_gen_kxk.sv
// window_gen_kxk: streaming KxK window generator for raster-order pixels.
// Keeps K-1 line buffers of MAX_W pixels (block RAM, registered read) and a
// KxK register window. One window is produced per valid convolution position
// of a runtime-sized frame, with valid/ready handshakes on both sides.
// Optional build macro WIN_STRIDE2_EN: emit only the positions where
// (row-(K-1)) and (col-(K-1)) are both even.
module window_gen_kxk #(
    parameter int DW    = 8,
    parameter int K     = 3,
    parameter int MAX_W = 64,
    parameter int CW    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CW-1:0]       img_width,
    input  logic [CW-1:0]       img_height,
    input  logic [DW-1:0]       s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [K*K*DW-1:0]   m_window,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                cfg_err
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CW-1:0] KW   = CW'(K);
    localparam logic [CW-1:0] KM1  = CW'(K - 1);
    localparam logic [CW-1:0] MAXW = CW'(MAX_W);

    logic [CW-1:0] col_reg, row_reg, col_next, row_next;
    logic [CW-1:0] width_reg, height_reg;
    logic [CW-1:0] eff_w, eff_h;
    logic          active_reg;
    logic          cfg_err_reg;
    logic          m_valid_reg;
    logic          m_last_reg;
    logic [DW-1:0] win_reg [K][K];
    logic [DW-1:0] lb_rd [K-1];

    logic accept, cfg_bad, take;
    logic col_wrap, row_last, frame_end;
    logic qualify, is_last;

    assign s_ready  = !cfg_err_reg && (!m_valid_reg || m_ready);
    assign m_valid  = m_valid_reg;
    assign m_last   = m_last_reg;
    assign cfg_err  = cfg_err_reg;

    // Position bookkeeping, frame-start config check and output qualification.
    always_comb begin
        eff_w     = active_reg ? width_reg  : img_width;
        eff_h     = active_reg ? height_reg : img_height;
        accept    = s_valid && s_ready;
        cfg_bad   = !active_reg &&
                    ((img_width < KW) || (img_width > MAXW) || (img_height < KW));
        take      = accept && !cfg_bad;
        col_wrap  = (col_reg == eff_w - CW'(1));
        row_last  = (row_reg == eff_h - CW'(1));
        frame_end = take && col_wrap && row_last;
`ifdef WIN_STRIDE2_EN
        // Even offsets from K-1 only; the last emitted row/col is h-1 or h-2
        // depending on the parity of (h-K), likewise for the width.
        qualify   = take && (row_reg >= KM1) && (col_reg >= KM1) &&
                    ((row_reg[0] ^ KM1[0]) == 1'b0) && ((col_reg[0] ^ KM1[0]) == 1'b0);
        is_last   = (row_reg == (((eff_h[0] ^ KW[0]) == 1'b1) ? eff_h - CW'(2) : eff_h - CW'(1))) &&
                    (col_reg == (((eff_w[0] ^ KW[0]) == 1'b1) ? eff_w - CW'(2) : eff_w - CW'(1)));
`else
        qualify   = take && (row_reg >= KM1) && (col_reg >= KM1);
        is_last   = col_wrap && row_last;
`endif
        col_next  = col_reg;
        row_next  = row_reg;
        if (rst) begin
            col_next = '0;
            row_next = '0;
        end else if (take) begin
            if (col_wrap) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + CW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    // Line buffers: buffer 0 holds the oldest row. The read address runs one
    // accept ahead (col_next) so the registered read of column c is ready when
    // pixel c arrives; the write address (col_reg) never equals it because
    // legal widths are at least 2.
    genvar gi, gj;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [DW-1:0] mem [MAX_W];
            logic [DW-1:0] rd_reg;
            logic [DW-1:0] wr_data;
            if (gi < K - 2) begin : g_mid
                assign wr_data = lb_rd[gi+1];
            end else begin : g_top
                assign wr_data = s_data;
            end
            // Shift the column up one buffer on accept; read ahead every cycle.
            always_ff @(posedge clk) begin
                if (take) begin
                    mem[col_reg[AW-1:0]] <= wr_data;
                end
                rd_reg <= mem[col_next[AW-1:0]];
            end
            assign lb_rd[gi] = rd_reg;
        end
    endgenerate

    // Window register: shift left one column and load the new rightmost column.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
        end else if (take) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_reg[r][c] <= win_reg[r][c+1];
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                win_reg[r][K-1] <= lb_rd[r];
            end
            win_reg[K-1][K-1] <= s_data;
        end
    end

    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                assign m_window[(gi*K+gj)*DW +: DW] = win_reg[gi][gj];
            end
        end
    endgenerate

    // Counters, frame state, config latch/error and output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg     <= '0;
            row_reg     <= '0;
            width_reg   <= '0;
            height_reg  <= '0;
            active_reg  <= 1'b0;
            cfg_err_reg <= 1'b0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (take && !active_reg) begin
                width_reg  <= img_width;
                height_reg <= img_height;
            end
            if (accept && cfg_bad) begin
                cfg_err_reg <= 1'b1;
            end
            if (take) begin
                active_reg <= !frame_end;
            end
            if (qualify) begin
                m_valid_reg <= 1'b1;
                m_last_reg  <= is_last;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_gen_kxk.sv
// tb_window_gen_kxk: randomized/directed bench for window_gen_kxk with an
// image-array reference model and a queue-based scoreboard.
module tb_window_gen_kxk;

    localparam int DW    = 8;
    localparam int K     = 3;
    localparam int MAX_W = 64;
    localparam int CW    = 7;
    localparam int WW    = K * K * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] img_width, img_height;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [WW-1:0] m_window;
    logic          m_valid, m_ready, m_last, cfg_err;

    always #5 clk = ~clk;

    window_gen_kxk #(.DW(DW), .K(K), .MAX_W(MAX_W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .img_width  (img_width),
        .img_height (img_height),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_window   (m_window),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .cfg_err    (cfg_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WW-1:0] win;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    int            n_popped = 0;
    bit            exp_mvalid = 1'b0;
    bit            exp_cfg_err = 1'b0;
    bit            f_active = 1'b0;
    int            f_w, f_h, f_r, f_c;
    logic [DW-1:0] img [128][MAX_W];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Is row/col index i an emitted window anchor (index of bottom/right edge)?
    function automatic bit emit_idx(input int i);
`ifdef WIN_STRIDE2_EN
        return (i >= K - 1) && (((i - (K - 1)) % 2) == 0);
`else
        return i >= K - 1;
`endif
    endfunction

    function automatic int last_pos(input int n);
        int p = -1;
        for (int i = 0; i < n; i++) if (emit_idx(i)) p = i;
        return p;
    endfunction

    function automatic int exp_windows(input int w, input int h);
`ifdef WIN_STRIDE2_EN
        return ((h - K + 2) / 2) * ((w - K + 2) / 2);
`else
        return (h - K + 1) * (w - K + 1);
`endif
    endfunction

    // Reference model: place the pixel in the frame image and, if its
    // position completes a window, push the KxK block read from the image.
    task automatic model_accept(input logic [DW-1:0] d, output bit qual);
        exp_t e;
        qual = 1'b0;
        if (!f_active) begin
            f_w = int'(img_width);
            f_h = int'(img_height);
            if (f_w < K || f_w > MAX_W || f_h < K) begin
                exp_cfg_err = 1'b1;
                return;
            end
            f_active = 1'b1;
            f_r = 0;
            f_c = 0;
        end
        img[f_r][f_c] = d;
        if (emit_idx(f_r) && emit_idx(f_c)) begin
            qual = 1'b1;
            for (int rr = 0; rr < K; rr++)
                for (int cc = 0; cc < K; cc++)
                    e.win[(rr*K+cc)*DW +: DW] = img[f_r-K+1+rr][f_c-K+1+cc];
            e.last = (f_r == last_pos(f_h)) && (f_c == last_pos(f_w));
            exp_q.push_back(e);
        end
        f_c++;
        if (f_c == f_w) begin
            f_c = 0;
            f_r++;
            if (f_r == f_h) f_active = 1'b0;
        end
    endtask

    // One clock cycle: check registered state, drive inputs, predict next state.
    task automatic step(input bit sv, input logic [DW-1:0] sd, input bit mr, output bit acc);
        bit qual, nv;
        @(negedge clk);
        chk("m_valid", m_valid, exp_mvalid);
        chk("cfg_err", cfg_err, exp_cfg_err);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        chk("s_ready", s_ready, !exp_cfg_err && (!exp_mvalid || mr));
        acc = sv && s_ready;
        nv  = exp_mvalid && !mr;
        if (acc) begin
            model_accept(sd, qual);
            if (qual) nv = 1'b1;
        end
        exp_mvalid = nv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_mvalid  = 1'b0;
        exp_cfg_err = 1'b0;
        f_active    = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_m_window", m_window, '0);
        chk("rst_s_ready", s_ready, 1'b1);
    endtask

    // mode 0: m_ready=1; mode 1: 3-cycle stall on first window; mode 2: random.
    task automatic send_frame(input int w, input int h, input int base, input int mode,
                              input int npix, input bit drain);
        bit acc, mr, sv, stalled;
        int tries, stall, n;
        logic [DW-1:0] d;
        img_width  = CW'(w);
        img_height = CW'(h);
        n = (npix < 0) ? w * h : npix;
        stall = 0;
        stalled = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = (mode == 2) ? DW'($urandom) : DW'(base + i);
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                mr = 1'b1;
                sv = 1'b1;
                if (mode == 1) begin
                    if (stall > 0) begin
                        mr = 1'b0;
                        stall--;
                    end else if (exp_mvalid && !stalled) begin
                        stalled = 1'b1;
                        stall = 2;
                        mr = 1'b0;
                    end
                end
                if (mode == 2) begin
                    mr = ($urandom % 4) != 0;
                    sv = ($urandom % 5) != 0;
                end
                step(sv, d, mr, acc);
                tries++;
                if (!acc && tries > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pixel_accept: pixel %0d not accepted in 50 cycles, required accept", i);
                    return;
                end
            end
        end
        if (drain) repeat (4) step(1'b0, '0, 1'b1, acc);
    endtask

    // Scoreboard monitor: pops on each window transfer, checks hold stability.
    logic [WW-1:0] held_win;
    bit            held_last;
    bit            holding = 1'b0;
    exp_t          got_e;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                chk("hold_m_valid", m_valid, 1'b1);
                chk("hold_m_window", m_window, held_win);
                chk("hold_m_last", m_last, held_last);
            end
            holding = 1'b0;
            if (m_valid && !m_ready) begin
                holding   = 1'b1;
                held_win  = m_window;
                held_last = m_last;
            end else if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_window: got %0h required no window", m_window);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("m_window", m_window, got_e.win);
                    chk("m_last", m_last, got_e.last);
                    n_popped++;
                    $display("window %0d: %0h last=%0b", n_popped, m_window, m_last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int p, w, h;
        bit acc;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        img_width = CW'(5);
        img_height = CW'(5);
        do_reset();

        p = n_popped;
        send_frame(5, 5, 0, 0, -1, 1'b1);
        chk("count_5x5", n_popped - p, exp_windows(5, 5));

        p = n_popped;
        send_frame(5, 5, 0, 1, -1, 1'b1);
        chk("count_5x5_stall", n_popped - p, exp_windows(5, 5));

        p = n_popped;
        send_frame(5, 5, 0, 0, -1, 1'b0);
        send_frame(4, 3, 100, 0, -1, 1'b1);
        chk("count_b2b", n_popped - p, exp_windows(5, 5) + exp_windows(4, 3));

        repeat (4) begin
            w = $urandom_range(K, 9);
            h = $urandom_range(K, 7);
            p = n_popped;
            send_frame(w, h, 0, 2, -1, 1'b1);
            chk("count_random", n_popped - p, exp_windows(w, h));
        end

        send_frame(5, 5, 0, 0, 9, 1'b0);
        do_reset();
        p = n_popped;
        send_frame(5, 5, 0, 0, -1, 1'b1);
        chk("count_after_rst", n_popped - p, exp_windows(5, 5));

        img_width = CW'(2);
        img_height = CW'(5);
        step(1'b1, 8'd7, 1'b1, acc);
        repeat (5) step(1'b1, 8'd8, 1'b1, acc);
        do_reset();
        p = n_popped;
        send_frame(5, 5, 50, 0, -1, 1'b1);
        chk("count_after_cfg_err", n_popped - p, exp_windows(5, 5));

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_gen_kxk.md
Name: window_gen_kxk

Overview:
- Parametrised successor of the fixed 3-row line buffer.
- Streams raster-order pixels and keeps K-1 line buffers sized for a compile-time maximum width.
- Image width and height are runtime values; emits one full KxK window per valid convolution position (no padding).
- Sits between the pixel source and the conv/MAC array; valid/ready handshake on both sides.

Parameters:
DW, 8, pixel width in bits
K, 3, window size (KxK), legal 2..7
MAX_W, 64, max image width (line buffer depth)
CW, 7, counter width; must hold MAX_W and max height

Ports:
clk  input  1  clock
rst  input  1  reset
img_width  input  CW  active line width; sampled at frame start
img_height  input  CW  active line count; sampled at frame start
s_data  input  DW  pixel in
s_valid  input  1  pixel valid
s_ready  output  1  block accepts pixel
m_window  output  K*K*DW  window; element (r,c) at [(r*K+c)*DW +: DW], r=0 oldest row, c=0 leftmost column
m_valid  output  1  window valid
m_ready  input  1  consumer accepts window
m_last  output  1  qualifies last window of frame
cfg_err  output  1  latched config error

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset clears col/row counters, frame-active flag, window regs, m_valid, m_last, cfg_err to 0. Line buffer contents need no reset.
- Handshakes:
  - Pixel accepted when s_valid && s_ready.
  - s_ready = !cfg_err && (!m_valid || m_ready).
  - Window transfers when m_valid && m_ready.
  - m_window and m_last hold stable while m_valid && !m_ready.
- Frame start, on the first accept with the frame-active flag clear:
  - Latch img_width and img_height.
  - If width < K, width > MAX_W, or height < K: set cfg_err, drop that pixel, stay idle. cfg_err stays set until rst.
- Per accepted pixel at (row, col):
  - Read line buffer slots lb[0..K-2][col].
  - Shift the window left one column; the new rightmost column is {lb[0][col], ..., lb[K-2][col], s_data}, top to bottom.
  - Write lb[j][col] <= lb[j+1][col] for j < K-2, and lb[K-2][col] <= s_data.
  - Advance col; when col = width-1, wrap to 0 and increment row.
- Output rule and latency:
  - m_valid asserts the cycle after an accept with row >= K-1 and col >= K-1 (one-cycle registered latency).
  - m_valid clears after the transfer unless a new qualifying accept occurs in the same cycle.
  - Window columns straddling a line wrap are never emitted.
- Frame end:
  - m_last = 1 with the window produced by pixel (height-1, width-1).
  - Counters and the frame-active flag clear in that accept cycle; the next accept starts a new frame with freshly sampled config.
  - Simultaneous transfer plus new accept is allowed; no bubble is required.
- Counts: one frame emits exactly (height-K+1)*(width-K+1) windows.
- Mid-frame rst: abort the frame, discard any pending window; the next pixel after reset is treated as (0,0).
- Line buffer holds stale data from a prior frame only in rows < K-1, which are never emitted.

Optional Feature:
- Macro WIN_STRIDE2_EN.
- Defined: a window is emitted only when (row-(K-1)) and (col-(K-1)) are both even. m_last goes with the last emitted window. A frame emits ceil((h-K+1)/2)*ceil((w-K+1)/2) windows. If the final pixel position is skipped, m_last goes with the last emitted window instead; the implementation flags that window when it is produced.
- Undefined: stride 1 as above; no extra logic.

Test Plan:
- K=3, w=5, h=5, pixels 0..24, m_ready=1 -> 9 windows. First window appears the cycle after pixel 12: rows {0,1,2},{5,6,7},{10,11,12}. Last window {12,13,14},{17,18,19},{22,23,24} with m_last=1.
- Same frame, m_ready low 3 cycles after the first window -> m_window is stable, s_ready=0, all 9 windows are delivered in order with no loss or duplication.
- Back-to-back frames w=5,h=5 then w=4,h=3 (pixels 100..111) -> 9 then 2 windows. Second frame yields {100,101,102},{104,105,106},{108,109,110} and {101,102,103},{105,106,107},{109,110,111}, the latter with m_last.
- rst asserted after pixel 8 of a 5x5 frame, then a full 5x5 frame is sent -> no window is output before the new frame's pixel 12, and there are 9 windows total.
- img_width=2 at frame start -> cfg_err=1 and s_ready=0 the next cycle. No m_valid until rst; after rst a valid config works.
- WIN_STRIDE2_EN, K=3, w=5, h=5 -> 4 windows centred at (1,1),(1,3),(3,1),(3,3). m_last is on the window ending at pixel 24.
